adc_stream_packer: RTL and testbench
====================================

Name: adc_stream_packer

Overview:
- Sits directly downstream of the ADC acquisition block.
- Consumes its 32-bit sample stream, which has no tready and so cannot be stalled. Buffers the stream in an internal FIFO.
- Re-emits the samples as a backpressured AXI4-Stream, with m_axis_tlast framing every PACKET_LEN words or on a flush request (end of trigger window).
- Feeds the DMA writer and reports overflow/packet statistics to the register bank.

Parameters:
- DATA_WIDTH, 32, stream word width.
- ADDR_WIDTH, 10, FIFO address bits; depth = 2^ADDR_WIDTH words.
- PACKET_LEN, 256, words per full packet; legal range 2..2^16.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  input word valid. There is no tready; every valid word must be taken.
- s_axis_tdata  in  DATA_WIDTH  input sample word.
- flush  in  1  one-cycle pulse: close the current packet.
- clear_status  in  1  one-cycle pulse: clear dropped_words, packets_sent and overflow.
- m_axis_tready  in  1  downstream ready.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tdata  out  DATA_WIDTH  output word.
- m_axis_tlast  out  1  last word of packet.
- fill_level  out  ADDR_WIDTH+1  current FIFO occupancy (excludes the hold register).
- dropped_words  out  32  words lost to a full FIFO; saturates at all-ones.
- packets_sent  out  32  count of output handshakes with tlast=1; wraps.
- overflow  out  1  sticky: set when any word has been dropped.

Behaviour:
- Reset values: all outputs 0; FIFO empty; hold register empty; pkt_cnt=0; flush_pending=0. Reset asserted mid-operation discards all buffered data immediately (asynchronously).
- Hold register: each accepted input word is first loaded into a one-word hold register. A word is only pushed to the FIFO once its tlast is known. This allows a flush to tag a word that has already arrived.
- flush_eff = flush | flush_pending.
- Push condition: hold_valid & (s_axis_tvalid | flush_eff). At most one push per cycle.
- Pushed tlast = flush_eff | (pkt_cnt == PACKET_LEN-1).
- pkt_cnt: increments on every push, including dropped pushes. It resets to 0 on a push with tlast=1.
- s_axis_tvalid=1: the new word loads into hold in the same cycle as any push; hold_valid stays 1.
- flush=1 together with s_axis_tvalid=1: the new word is defined as the last of the packet.
  - The old hold word is pushed with count-based tlast only.
  - flush_pending is set.
  - Next cycle the hold word is pushed with tlast=1 and flush_pending clears. A word arriving that cycle loads into hold as the first word of the new packet.
- flush with hold empty and no input word: ignored; no state change.
- flush with hold valid and no input word: push with tlast=1; hold becomes empty.
- FIFO full on a push: the word is dropped.
  - dropped_words increments (saturating) and overflow is set.
  - pkt_cnt still advances, so packet boundaries stay aligned to input word index.
  - A dropped tlast word is simply lost.
- FIFO: synchronous memory with first-word-fall-through output.
  - A word pushed at edge N into an empty FIFO gives m_axis_tvalid=1 after edge N+1.
  - Pop on m_axis_tvalid & m_axis_tready.
  - Simultaneous push and pop when full: the push is accepted and fill_level is unchanged.
  - Simultaneous push and pop when empty is impossible under FWFT; the word appears next cycle.
- AXI rules: tdata/tlast stay stable while tvalid & !tready. tvalid never depends combinationally on tready.
- fill_level updates one cycle after the push/pop edge. Pointers wrap modulo depth, with the extra MSB distinguishing full from empty.
- packets_sent increments on m_axis handshake with tlast=1.
- clear_status: counters/flag go to 0 next edge. An increment in the same cycle is lost; clear has priority.

Test Plan:
1. PACKET_LEN=4, tready=1: words 1..9 on consecutive cycles, flush one cycle after word 9 -> output 1..9 in order; tlast on 4, 8, 9; packets_sent=3.
2. PACKET_LEN=4: words A,B,C with flush asserted on C's cycle, then D,E -> tlast on C; D starts a new packet (tlast on the 4th word after C).
3. ADDR_WIDTH=3, PACKET_LEN=16, tready=0, 12 words -> fill_level=8, dropped_words=3, overflow=1, word 12 held. Then tready=1 -> words 1..8 emitted in order.
4. tready toggled every 2 cycles during a 20-word stream -> no loss/duplication; tdata stable while stalled; word order preserved.
5. flush with hold empty -> no output and no counter change. Then clear_status after scenario 3 -> dropped_words=0, overflow=0, packets_sent=0 next cycle.
6. aresetn low for 1 cycle while fill_level=5 and pkt_cnt=2 -> tvalid=0 and all counters 0 immediately. After release, PACKET_LEN words yield tlast exactly on the PACKET_LEN-th word.

Source files
------------

// File: rtl/adc_stream_packer.sv
// Packs a non-stallable ADC sample stream into AXI4-Stream packets.
// A one-word hold register lets a flush tag a word that has already arrived.
module adc_stream_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int PACKET_LEN = 256
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  flush,
  input  logic                  clear_status,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic [31:0]           dropped_words,
  output logic [31:0]           packets_sent,
  output logic                  overflow
);

  localparam int                DEPTH      = 1 << ADDR_WIDTH;
  localparam int                CNT_W      = (PACKET_LEN > 2) ? $clog2(PACKET_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PACKET_LEN - 1);
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);

  // Each entry stores {tlast, data}.
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  flush_pending_q, flush_pending_d;
  logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic [31:0]           dropped_q, dropped_d;
  logic [31:0]           packets_q, packets_d;
  logic                  overflow_q, overflow_d;

  logic                  flush_eff;
  logic                  push;
  logic                  push_last;
  logic                  pop;
  logic                  accept;
  logic                  drop;
  logic [ADDR_WIDTH:0]   level;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    hold_valid_d    = hold_valid_q;
    hold_data_d     = hold_data_q;
    pkt_cnt_d       = pkt_cnt_q;
    dropped_d       = dropped_q;
    packets_d       = packets_q;
    overflow_d      = overflow_q;

    flush_eff = flush | flush_pending_q;
    push      = hold_valid_q & (s_axis_tvalid | flush_eff);
    // A flush arriving with a new word tags the new word, not the held one.
    push_last = flush_pending_q | (flush & ~s_axis_tvalid) | (pkt_cnt_q == CNT_LAST);
    pop       = out_valid_q & m_axis_tready;
    level     = wr_ptr_q - rd_ptr_q;
    accept    = push & ((level != FULL_LEVEL) | pop);
    drop      = push & ~accept;

    if (s_axis_tvalid) begin
      hold_valid_d = 1'b1;
      hold_data_d  = s_axis_tdata;
    end else if (push) begin
      hold_valid_d = 1'b0;
    end
    flush_pending_d = flush & s_axis_tvalid;

    // Dropped pushes still advance the count to keep framing aligned to input index.
    if (push) pkt_cnt_d = push_last ? '0 : pkt_cnt_q + CNT_W'(1);

    wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(accept);
    rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(pop);
    // The output stage re-reads the head slot each cycle; it is never overwritten while occupied.
    out_valid_d = (wr_ptr_q != rd_ptr_d);

    if (drop && (dropped_q != '1)) dropped_d = dropped_q + 32'd1;
    if (drop) overflow_d = 1'b1;
    if (pop && out_last_q) packets_d = packets_q + 32'd1;
    if (clear_status) begin
      dropped_d  = '0;
      packets_d  = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_valid_q    <= 1'b0;
      hold_data_q     <= '0;
      flush_pending_q <= 1'b0;
      pkt_cnt_q       <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_last_q      <= 1'b0;
      dropped_q       <= '0;
      packets_q       <= '0;
      overflow_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      hold_valid_q    <= hold_valid_d;
      hold_data_q     <= hold_data_d;
      flush_pending_q <= flush_pending_d;
      pkt_cnt_q       <= pkt_cnt_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      out_valid_q     <= out_valid_d;
      if (out_valid_d) {out_last_q, out_data_q} <= mem[rd_ptr_d[ADDR_WIDTH-1:0]];
      dropped_q       <= dropped_d;
      packets_q       <= packets_d;
      overflow_q      <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge aclk) begin
    if (accept) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {push_last, hold_data_q};
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign fill_level    = level;
  assign dropped_words = dropped_q;
  assign packets_sent  = packets_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_adc_stream_packer.sv
// Bench for adc_stream_packer: directed scenarios plus randomized traffic,
// scored against a word-level packet model.
module tb_adc_stream_packer;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int PL = 4;
  localparam int DEPTH = 1 << AW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          flush = 1'b0;
  logic          clear_status = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [AW:0]   fill_level;
  logic [31:0]   dropped_words;
  logic [31:0]   packets_sent;
  logic          overflow;

  adc_stream_packer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PACKET_LEN(PL)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .flush(flush), .clear_status(clear_status),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .fill_level(fill_level), .dropped_words(dropped_words),
    .packets_sent(packets_sent), .overflow(overflow)
  );

  always #5 aclk = ~aclk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: words are closed into packets as their fate becomes known.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic          mdl_open = 1'b0;
  logic [DW-1:0] mdl_data = '0;
  logic          mdl_tag  = 1'b0;
  int            mdl_pos   = 0;
  int            mdl_drops = 0;
  int            mdl_pkts  = 0;
  int            room      = -1;   // free FIFO slots while output is stalled; -1 = not tracked

  task automatic close_word(input logic force_last);
    logic last;
    last    = mdl_tag | force_last | (mdl_pos == PL - 1);
    mdl_pos = last ? 0 : mdl_pos + 1;
    if (room == 0) mdl_drops++;
    else begin
      if (room > 0) room--;
      exp_q.push_back('{data: mdl_data, last: last});
    end
    mdl_open = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic f);
    if (mdl_open && mdl_tag) close_word(1'b1);
    if (v) begin
      if (mdl_open) close_word(1'b0);
      mdl_open = 1'b1;
      mdl_data = d;
      mdl_tag  = f;
    end else if (f && mdl_open) begin
      close_word(1'b1);
    end
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic f, input logic rdy);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    flush         = f;
    m_axis_tready = rdy;
    @(posedge aclk);
    #1;
    model_step(v, d, f);
    s_axis_tvalid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < budget) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_fill"}, fill_level, 0);
  endtask

  // Output monitor: scoreboard each handshake, and hold-stability while stalled.
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  always @(negedge aclk) begin
    if (aresetn) begin
      if (prev_stall) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_beat", {m_axis_tdata, m_axis_tlast}, prev_beat);
      end
      prev_stall = m_axis_tvalid & ~m_axis_tready;
      prev_beat  = '{data: m_axis_tdata, last: m_axis_tlast};
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_queued", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat", {m_axis_tdata, m_axis_tlast}, e);
          if (e.last) mdl_pkts++;
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge aclk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_fill", fill_level, 0);
    check("rst_dropped", dropped_words, 0);
    check("rst_pkts", packets_sent, 0);
    check("rst_ovf", overflow, 0);
    aresetn = 1'b1;

    // Nine words then a flush: tlast on 4, 8, 9.
    for (int i = 1; i <= 9; i++) cycle(1'b1, DW'(i), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    drain("t1", 50);
    check("t1_pkts", packets_sent, 3);

    // Flush coincident with word C closes the packet on C.
    cycle(1'b1, 32'hA, 1'b0, 1'b1);
    cycle(1'b1, 32'hB, 1'b0, 1'b1);
    cycle(1'b1, 32'hC, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hD + DW'(i), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    drain("t2", 50);
    check("t2_pkts", packets_sent, 6);

    // Overflow while the output is stalled.
    room = DEPTH;
    for (int i = 1; i <= DEPTH + 4; i++) cycle(1'b1, 32'h300 + DW'(i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t3_fill", fill_level, DEPTH);
    check("t3_dropped", dropped_words, 3);
    check("t3_model_drops", dropped_words, mdl_drops);
    check("t3_ovf", overflow, 1);
    check("t3_head", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'h301});
    room = -1;
    drain("t3", 100);
    check("t3_pkts", packets_sent, 10);

    // Clear status, then release the word still in the hold register.
    clear_status = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b1);
    clear_status = 1'b0;
    mdl_pkts  = 0;
    mdl_drops = 0;
    check("clr_dropped", dropped_words, 0);
    check("clr_ovf", overflow, 0);
    check("clr_pkts", packets_sent, 0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    drain("t5", 50);
    check("t5_pkts", packets_sent, 1);

    // Flush with nothing held does nothing.
    cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    check("empty_flush_valid", m_axis_tvalid, 0);
    check("empty_flush_fill", fill_level, 0);
    check("empty_flush_pkts", packets_sent, 1);

    // Back-to-back burst with tready toggling every two cycles, then random traffic.
    for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 1'b0, ((i / 2) % 2) == 0);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    drain("rnd", 200);
    check("rnd_dropped", dropped_words, mdl_drops);
    check("rnd_ovf", overflow, 0);
    check("rnd_pkts", packets_sent, mdl_pkts);

    // Mid-operation reset with fill_level=5 and two words into the open packet.
    cycle(1'b1, 32'h601, 1'b0, 1'b0);
    cycle(1'b1, 32'h602, 1'b0, 1'b0);
    cycle(1'b1, 32'h603, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 32'h604, 1'b0, 1'b0);
    cycle(1'b1, 32'h605, 1'b0, 1'b0);
    cycle(1'b1, 32'h606, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t6_fill", fill_level, 5);
    aresetn = 1'b0;
    exp_q.delete();
    mdl_open  = 1'b0;
    mdl_pos   = 0;
    mdl_drops = 0;
    mdl_pkts  = 0;
    #1;
    check("t6_tvalid", m_axis_tvalid, 0);
    check("t6_fill0", fill_level, 0);
    check("t6_pkts0", packets_sent, 0);
    check("t6_dropped0", dropped_words, 0);
    check("t6_ovf0", overflow, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    for (int i = 1; i <= PL + 1; i++) cycle(1'b1, 32'h700 + DW'(i), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    drain("t6", 50);
    check("t6_pkts", packets_sent, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
